// File: rtl/fiat_25519_pkg.sv
// rtl/fiat_25519_pkg.sv - shared constants, limb geometry and state encoding for the fiat_25519 limb accumulator
package fiat_25519_pkg;

  localparam int NLIMBS        = 10;
  localparam int WRAP_MULT_DEF = 19;

  typedef enum logic [2:0] {
    ST_ACCUM,
    ST_CARRY,
    ST_WRAP,
    ST_FIX,
    ST_EMIT
  } state_t;

  // Radix 2^25.5: even limbs hold 26 bits, odd limbs hold 25 bits
  function automatic int limb_w(input int i);
    return (i % 2 == 0) ? 26 : 25;
  endfunction

  function automatic logic [63:0] limb_mask(input int i);
    return (64'd1 << limb_w(i)) - 64'd1;
  endfunction

endpackage

// File: rtl/fiat_25519_carry_step.sv
// rtl/fiat_25519_carry_step.sv - one radix-2^25.5 carry step: mask the low limb, push its overflow upward
module fiat_25519_carry_step
  import fiat_25519_pkg::*;
#(
  parameter int ACC_W = 64
) (
  input  logic [ACC_W-1:0] acc_lo,
  input  logic [ACC_W-1:0] acc_hi,
  input  logic             odd_sel,
  output logic [ACC_W-1:0] lo_out,
  output logic [ACC_W-1:0] hi_out
);

  // Width of the low limb is 25 bits when it sits at an odd index, 26 otherwise
  always_comb begin
    lo_out = acc_lo & ACC_W'(limb_mask(odd_sel ? 1 : 0));
    hi_out = acc_hi + (acc_lo >> limb_w(odd_sel ? 1 : 0));
  end

endmodule

// File: rtl/fiat_25519_limb_carry_accum.sv
// rtl/fiat_25519_limb_carry_accum.sv - column accumulator, carry chain with 2^255=19 wrap, limb streamer
module fiat_25519_limb_carry_accum
  import fiat_25519_pkg::*;
#(
  parameter int ACC_W     = 64,
  parameter int TERM_W    = 64,
  parameter int OUT_W     = 32,
  parameter int WRAP_MULT = WRAP_MULT_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [TERM_W-1:0] term_data,
  input  logic [3:0]        term_limb,
  input  logic              term_last,
  input  logic              term_valid,
  output logic              term_ready,
  output logic [OUT_W-1:0]  out_limb,
  output logic [3:0]        out_idx,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [ACC_W-1:0] acc [NLIMBS];
  logic [ACC_W-1:0] c9;
  state_t           state;
  logic [3:0]       k;

  logic [3:0]       lo_idx;
  logic [3:0]       hi_idx;
  logic [ACC_W-1:0] step_lo;
  logic [ACC_W-1:0] step_hi;
  logic [ACC_W-1:0] step_lo_m;
  logic [ACC_W-1:0] step_hi_s;

  // Select the limb pair feeding the shared carry adder: column k in CARRY, column 0 in FIX.
  // At k=9 the upper operand is zero so the adder output is the raw carry c9.
  always_comb begin
    lo_idx  = (state == ST_FIX) ? 4'd0 : k;
    hi_idx  = (lo_idx >= 4'd9) ? 4'd0 : lo_idx + 4'd1;
    step_lo = acc[lo_idx];
    step_hi = (lo_idx >= 4'd9) ? '0 : acc[hi_idx];
  end

  fiat_25519_carry_step #(
    .ACC_W(ACC_W)
  ) u_step (
    .acc_lo (step_lo),
    .acc_hi (step_hi),
    .odd_sel(lo_idx[0]),
    .lo_out (step_lo_m),
    .hi_out (step_hi_s)
  );

  // Frame sequencer: accumulate, carry, wrap, fix, then stream ten limbs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NLIMBS; i++) acc[i] <= '0;
      c9         <= '0;
      state      <= ST_ACCUM;
      k          <= '0;
      term_ready <= 1'b1;
      out_valid  <= 1'b0;
      out_limb   <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (term_valid && term_ready) begin
            // Out-of-range columns are swallowed but still close the frame
            if (term_limb < 4'd10)
              acc[term_limb] <= acc[term_limb] + ACC_W'(term_data);
            if (term_last) begin
              state      <= ST_CARRY;
              k          <= '0;
              term_ready <= 1'b0;
            end
          end
        end
        ST_CARRY: begin
          acc[lo_idx] <= step_lo_m;
          if (k == 4'd9) begin
            c9    <= step_hi_s;
            state <= ST_WRAP;
          end else begin
            acc[hi_idx] <= step_hi_s;
            k           <= k + 4'd1;
          end
        end
        ST_WRAP: begin
          acc[0] <= acc[0] + ACC_W'(WRAP_MULT) * c9;
          state  <= ST_FIX;
        end
        ST_FIX: begin
          // Limb 1 may end up one carry above its mask here; that loose bound is accepted
          acc[0]    <= step_lo_m;
          acc[1]    <= step_hi_s;
          state     <= ST_EMIT;
          out_valid <= 1'b1;
          out_idx   <= '0;
          out_last  <= 1'b0;
          out_limb  <= OUT_W'(step_lo_m);
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (out_idx == 4'd9) begin
              for (int i = 0; i < NLIMBS; i++) acc[i] <= '0;
              c9         <= '0;
              state      <= ST_ACCUM;
              term_ready <= 1'b1;
              out_valid  <= 1'b0;
              out_limb   <= '0;
              out_idx    <= '0;
              out_last   <= 1'b0;
            end else begin
              out_idx  <= out_idx + 4'd1;
              out_limb <= OUT_W'(acc[out_idx + 4'd1]);
              out_last <= (out_idx == 4'd8);
            end
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_fiat_25519_limb_carry_accum.sv
// tb/tb_fiat_25519_limb_carry_accum.sv - directed table-driven bench for the limb carry accumulator
module tb_fiat_25519_limb_carry_accum;

  logic        ap_clk;
  logic        ap_rst_n;
  logic [63:0] term_data;
  logic [3:0]  term_limb;
  logic        term_last;
  logic        term_valid;
  logic        term_ready;
  logic [31:0] out_limb;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  fiat_25519_limb_carry_accum dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .term_data (term_data),
    .term_limb (term_limb),
    .term_last (term_last),
    .term_valid(term_valid),
    .term_ready(term_ready),
    .out_limb  (out_limb),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int                 nterms;
    logic [11:0][63:0]  data;
    logic [11:0][3:0]   limb;
    logic [9:0][31:0]   exp;
    int                 stall;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic send_term(input logic [63:0] d, input logic [3:0] l, input logic last);
    int guard = 0;
    term_data  = d;
    term_limb  = l;
    term_last  = last;
    term_valid = 1'b1;
    while (!term_ready && guard < 100) begin
      @(posedge ap_clk); #1;
      guard++;
    end
    if (!term_ready) chk("term_ready_timeout", {63'd0, term_ready}, 64'd1);
    @(posedge ap_clk); #1;
    term_valid = 1'b0;
    term_last  = 1'b0;
  endtask

  task automatic collect(input logic [9:0][31:0] exp, input int stall, input string tag);
    int guard = 0;
    while (!out_valid && guard < 40) begin
      @(posedge ap_clk); #1;
      guard++;
    end
    chk($sformatf("%s out_valid_wait", tag), {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s valid[%0d]", tag, i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("%s idx[%0d]", tag, i), {60'd0, out_idx}, i);
      chk($sformatf("%s last[%0d]", tag, i), {63'd0, out_last}, (i == 9) ? 64'd1 : 64'd0);
      chk($sformatf("%s limb[%0d]", tag, i), {32'd0, out_limb}, {32'd0, exp[i]});
      if (i == stall) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge ap_clk); #1;
          chk($sformatf("%s stall_idx", tag), {60'd0, out_idx}, i);
          chk($sformatf("%s stall_limb", tag), {32'd0, out_limb}, {32'd0, exp[i]});
          chk($sformatf("%s stall_valid", tag), {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
      end
      @(posedge ap_clk); #1;
    end
    chk($sformatf("%s done_valid", tag), {63'd0, out_valid}, 64'd0);
    chk($sformatf("%s done_ready", tag), {63'd0, term_ready}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0][31:0] e;

    ap_rst_n   = 1'b0;
    term_data  = '0;
    term_limb  = '0;
    term_last  = 1'b0;
    term_valid = 1'b0;
    out_ready  = 1'b1;

    for (int v = 0; v < 5; v++) begin
      vecs[v].nterms = 1;
      vecs[v].data   = '0;
      vecs[v].limb   = '0;
      vecs[v].exp    = '0;
      vecs[v].stall  = -1;
    end
    // 2^26+5 in limb 0 -> [5,1,0..]
    vecs[0].data[0] = 64'd67108869;
    vecs[0].exp[0]  = 32'd5;
    vecs[0].exp[1]  = 32'd1;
    // 2^25 in limb 9 -> c9=1 -> [19,0..]
    vecs[1].data[0] = 64'd33554432;
    vecs[1].limb[0] = 4'd9;
    vecs[1].exp[0]  = 32'd19;
    // every limb at its mask, plus 1 in limb 0: full ripple, 2^255 == 19
    vecs[2].nterms = 11;
    for (int i = 0; i < 10; i++) begin
      vecs[2].data[i] = (i % 2 == 0) ? 64'd67108863 : 64'd33554431;
      vecs[2].limb[i] = 4'(i);
    end
    vecs[2].data[10] = 64'd1;
    vecs[2].limb[10] = 4'd0;
    vecs[2].exp[0]   = 32'd19;
    // out-of-range column is discarded; back-pressure at idx 3
    vecs[3].data[0] = 64'd12345;
    vecs[3].limb[0] = 4'd12;
    vecs[3].stall   = 3;
    // 2^47 in limb 9 and 2^25-1 in limb 1: wrap 19*2^22 = 2^26 + 3*2^22, FIX pushes limb1 to 2^25
    vecs[4].nterms  = 2;
    vecs[4].data[0] = 64'd33554431;
    vecs[4].limb[0] = 4'd1;
    vecs[4].data[1] = 64'd140737488355328;
    vecs[4].limb[1] = 4'd9;
    vecs[4].exp[0]  = 32'd12582912;
    vecs[4].exp[1]  = 32'd33554432;

    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst term_ready", {63'd0, term_ready}, 64'd1);
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst out_limb", {32'd0, out_limb}, 64'd0);
    chk("rst out_idx", {60'd0, out_idx}, 64'd0);
    chk("rst out_last", {63'd0, out_last}, 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    for (int v = 0; v < 5; v++) begin
      for (int t = 0; t < vecs[v].nterms; t++)
        send_term(vecs[v].data[t], vecs[v].limb[t], (t == vecs[v].nterms - 1));
      repeat (11) @(posedge ap_clk);
      #1;
      chk($sformatf("v%0d latency_early", v), {63'd0, out_valid}, 64'd0);
      chk($sformatf("v%0d ready_busy", v), {63'd0, term_ready}, 64'd0);
      @(posedge ap_clk); #1;
      chk($sformatf("v%0d latency_rise", v), {63'd0, out_valid}, 64'd1);
      collect(vecs[v].exp, vecs[v].stall, $sformatf("v%0d", v));
    end

    // Three terms into limb 2, then a term held during CARRY that opens the next frame
    send_term(64'd100, 4'd2, 1'b0);
    send_term(64'd200, 4'd2, 1'b0);
    send_term(64'd300, 4'd2, 1'b1);
    term_data  = 64'd7;
    term_limb  = 4'd0;
    term_last  = 1'b0;
    term_valid = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("held ready_low", {63'd0, term_ready}, 64'd0);
    e    = '0;
    e[2] = 32'd600;
    collect(e, -1, "sum600");
    @(posedge ap_clk); #1;
    term_valid = 1'b0;
    send_term(64'd3, 4'd1, 1'b1);
    e    = '0;
    e[0] = 32'd7;
    e[1] = 32'd3;
    collect(e, -1, "held");

    // Reset in the middle of CARRY (k=4)
    send_term(64'd67108869, 4'd0, 1'b1);
    repeat (4) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    chk("midrst term_ready", {63'd0, term_ready}, 64'd1);
    chk("midrst out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst out_limb", {32'd0, out_limb}, 64'd0);
    chk("midrst out_idx", {60'd0, out_idx}, 64'd0);
    chk("midrst out_last", {63'd0, out_last}, 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    send_term(64'd7, 4'd0, 1'b1);
    e    = '0;
    e[0] = 32'd7;
    collect(e, -1, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
